// File: rtl/divider_iter_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The requester drives operands and out_ready; the divider returns the HI/LO result.
interface divider_iter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output in_valid, sign, srca, srcb, out_ready,
    input  in_ready, out_valid, hi, lo, div_by_zero
  );

  modport slave (
    input  in_valid, sign, srca, srcb, out_ready,
    output in_ready, out_valid, hi, lo, div_by_zero
  );
endinterface

// File: rtl/divider_iter.sv
// Iterative restoring divider, RADIX_BITS quotient bits per cycle, signed/unsigned.
// Remainder is returned on hi, quotient on lo; divide-by-zero takes a short path from PREP.
module divider_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  output logic          busy,
  divider_iter_if.slave bus
);
  localparam int unsigned N    = WIDTH / RADIX_BITS;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             in_ready;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   rem_c;
  logic [WIDTH-1:0] quo_c;

  // quo_q holds the raw dividend until PREP, then the shifting dividend/quotient.
  assign a_neg = sign_q & quo_q[WIDTH-1];
  assign b_neg = sign_q & dvs_q[WIDTH-1];

  // RADIX_BITS chained restoring steps; rem_c is one bit wider to hold 2*rem before compare.
  always_comb begin
    rem_c = {1'b0, rem_q};
    quo_c = quo_q;
    for (int i = 0; i < int'(RADIX_BITS); i++) begin
      rem_c = {rem_c[WIDTH-1:0], quo_c[WIDTH-1]};
      quo_c = {quo_c[WIDTH-2:0], 1'b0};
      if (rem_c >= {1'b0, dvs_q}) begin
        rem_c    = rem_c - {1'b0, dvs_q};
        quo_c[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready) begin
          sign_d  = bus.sign;
          quo_d   = bus.srca;
          dvs_d   = bus.srcb;
          state_d = StPrep;
        end
      end
      StPrep: begin
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        if (dvs_q == '0) begin
          lo_d    = '1;
          hi_d    = quo_q;
          dbz_d   = 1'b1;
          state_d = StDone;
        end else begin
          quo_d   = a_neg ? -quo_q : quo_q;
          dvs_d   = b_neg ? -dvs_q : dvs_q;
          rem_d   = '0;
          cnt_d   = CntW'(N);
          state_d = StCalc;
        end
      end
      StCalc: begin
        quo_d = quo_c;
        rem_d = rem_c[WIDTH-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Cancel drops any in-flight or pending result; hi/lo keep their last values.
    if (flush) begin
      state_d = StIdle;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready        = (state_q == StIdle) && !flush;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == StDone);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
  assign busy            = (state_q != StIdle);
endmodule
